// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding and default sizing.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    localparam int WORD           = 64;
    localparam int MEM_BYTES_DEF  = 1024;
    localparam int STARVE_LIM_DEF = 4;

endpackage

// File: rtl/dmem_arbiter_starve.sv
// Grant selection with a saturating starvation counter that forces port 1
// through after STARVE_LIM consecutive port-0 grants while port 1 waits.
module dmem_arbiter_starve
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF,
    parameter int CNT_W      = $clog2(STARVE_LIM + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             grant_en,
    output logic             sel,
    output logic [CNT_W-1:0] cnt
);

    logic starved;

    assign starved = (cnt == CNT_W'(STARVE_LIM));
    assign sel     = req1 && (!req0 || starved);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (grant_en) begin
            // Only a port-0 grant that bypasses a waiting port 1 counts.
            if (sel || !req1) begin
                cnt <= '0;
            end else if (!starved) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter serialising doubleword transactions from the CPU (port 0)
// and the loader (port 1) onto the single data memory.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = WORD,
    parameter int MEM_BYTES  = MEM_BYTES_DEF,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIM + 1);

    arb_state_t        state;
    logic              owner;
    logic              we_l;
    logic              legal_l;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;
    logic              sel;
    logic              grant_en;
    logic [CNT_W-1:0]  starve_cnt;
    logic              unused_cnt;

    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return (a[2:0] == 3'b000) && (a <= ADDR_W'(MEM_BYTES - 8));
    endfunction

    assign grant_en   = (state == ARB_IDLE) && (req0 || req1);
    assign unused_cnt = ^starve_cnt;

    dmem_arbiter_starve #(
        .STARVE_LIM (STARVE_LIM),
        .CNT_W      (CNT_W)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .grant_en (grant_en),
        .sel      (sel),
        .cnt      (starve_cnt)
    );

    // Memory side is decoded from registered state only; illegal accesses keep the bus quiet.
    assign mem_read  = (state == ARB_BUSY) && legal_l && !we_l;
    assign mem_write = (state == ARB_BUSY) && legal_l &&  we_l;
    assign mem_addr  = (state == ARB_BUSY && legal_l) ? addr_l : '0;
    assign mem_wdata = (state == ARB_BUSY && legal_l && we_l) ? wdata_l : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB_IDLE;
            owner   <= 1'b0;
            we_l    <= 1'b0;
            legal_l <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            rdata   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_en) begin
                        owner   <= sel;
                        we_l    <= sel ? we1 : we0;
                        addr_l  <= sel ? addr1 : addr0;
                        wdata_l <= sel ? wdata1 : wdata0;
                        legal_l <= addr_legal(sel ? addr1 : addr0);
                        state   <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    rdata <= (legal_l && !we_l) ? mem_rdata : '0;
                    ack0  <= !owner;
                    ack1  <= owner;
                    err0  <= !owner && !legal_l;
                    err1  <= owner && !legal_l;
                    state <= ARB_RESP;
                end
                ARB_RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int MEM_BYTES  = 1024;
    localparam int STARVE_LIM = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              ack0, ack1, err0, err1;
    logic [DATA_W-1:0] rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem [0:127];
    logic              pre_we = 1'b0;
    logic [6:0]        pre_idx = '0;
    logic [DATA_W-1:0] pre_val = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:3]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        else if (mem_write) mem[mem_addr[9:3]] <= mem_wdata;
    end

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic preload(input int idx, input logic [DATA_W-1:0] v);
        @(negedge clk);
        pre_idx = idx[6:0];
        pre_val = v;
        pre_we  = 1'b1;
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    task automatic start0(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({ack0, ack1, err0, err1, mem_read, mem_write} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b required 000000", {ack0, ack1, err0, err1, mem_read, mem_write});
        end
        n_cmp++;
        if (mem_addr !== '0) begin n_err++; $display("FAIL reset_addr: got %h required 0", mem_addr); end
        n_cmp++;
        if (mem_wdata !== '0) begin n_err++; $display("FAIL reset_wdata: got %h required 0", mem_wdata); end
        n_cmp++;
        if (rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h required 0", rdata); end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ack0, ack1, mem_read, mem_write} !== 4'b0 || mem_addr !== '0) begin
                n_err++;
                $display("FAIL idle_%0d: got ctrl=%b addr=%h required 0000/0", i, {ack0, ack1, mem_read, mem_write}, mem_addr);
            end
        end
    endtask

    task automatic test_single_read();
        start0(1'b0, 64'h10, '0);
        @(negedge clk);
        n_cmp++;
        if (mem_read !== 1'b1 || mem_addr !== 64'h10 || ack0 !== 1'b0) begin
            n_err++; $display("FAIL rd_busy: got rd=%b addr=%h ack=%b required 1/10/0", mem_read, mem_addr, ack0);
        end
        @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b1 || err0 !== 1'b0 || mem_read !== 1'b0) begin
            n_err++; $display("FAIL rd_ack: got ack=%b err=%b rd=%b required 1/0/0", ack0, err0, mem_read);
        end
        n_cmp++;
        if (rdata !== 64'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h required deadbeef", rdata); end
        req0 = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 64'h20; wdata1 = 64'h1234;
        @(negedge clk);
        n_cmp++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 64'h20 || mem_wdata !== 64'h1234) begin
            n_err++;
            $display("FAIL wr_busy: got wr=%b rd=%b addr=%h wdata=%h required 1/0/20/1234", mem_write, mem_read, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || err1 !== 1'b0 || mem_write !== 1'b0) begin
            n_err++; $display("FAIL wr_ack: got ack1=%b ack0=%b err1=%b wr=%b required 1/0/0/0", ack1, ack0, err1, mem_write);
        end
        req1 = 1'b0; we1 = 1'b0;
        start0(1'b0, 64'h20, '0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b1 || rdata !== 64'h1234) begin
            n_err++; $display("FAIL wr_readback: got ack=%b data=%h required 1/1234", ack0, rdata);
        end
        req0 = 1'b0;
    endtask

    task automatic test_starvation();
        int exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        int got;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 64'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 64'h20;
        for (int i = 0; i < 10; i++) begin
            got = -1;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (ack0 && ack1) begin got = 2; break; end
                if (ack0) begin got = 0; break; end
                if (ack1) begin got = 1; break; end
            end
            n_cmp++;
            if (got != exp_order[i]) begin
                n_err++; $display("FAIL grant_%0d: got port %0d required port %0d", i, got, exp_order[i]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_illegal();
        logic [ADDR_W-1:0] bad [2] = '{64'h13, 64'd1024};
        for (int i = 0; i < 2; i++) begin
            start0(1'b0, bad[i], '0);
            @(negedge clk);
            n_cmp++;
            if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
                n_err++; $display("FAIL illegal_strobe_%h: got rd=%b wr=%b required 0/0", bad[i], mem_read, mem_write);
            end
            @(negedge clk);
            n_cmp++;
            if (ack0 !== 1'b1 || err0 !== 1'b1 || rdata !== '0) begin
                n_err++; $display("FAIL illegal_resp_%h: got ack=%b err=%b data=%h required 1/1/0", bad[i], ack0, err0, rdata);
            end
            req0 = 1'b0;
        end
        start0(1'b0, 64'd1016, '0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b1 || err0 !== 1'b0 || rdata !== 64'hA5A5_0000_5A5A) begin
            n_err++; $display("FAIL top_word: got ack=%b err=%b data=%h required 1/0/a5a500005a5a", ack0, err0, rdata);
        end
        req0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int late_acks = 0;
        start0(1'b0, 64'h10, '0);
        @(negedge clk);
        n_cmp++;
        if (mem_read !== 1'b1) begin n_err++; $display("FAIL mid_busy: got rd=%b required 1", mem_read); end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_read, mem_write, ack0, ack1, err0, err1} !== 6'b0 || mem_addr !== '0 || rdata !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got ctrl=%b addr=%h data=%h required 0/0/0", {mem_read, mem_write, ack0, ack1, err0, err1}, mem_addr, rdata);
        end
        @(negedge clk);
        req0 = 1'b0;
        rst  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ack0 || ack1) late_acks++;
        end
        n_cmp++;
        if (late_acks != 0) begin n_err++; $display("FAIL mid_noack: got %0d acks required 0", late_acks); end
        start0(1'b0, 64'h10, '0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ack0 !== 1'b1 || rdata !== 64'hDEADBEEF) begin
            n_err++; $display("FAIL mid_reissue: got ack=%b data=%h required 1/deadbeef", ack0, rdata);
        end
        req0 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        test_reset();
        preload(2, 64'hDEADBEEF);
        preload(127, 64'hA5A5_0000_5A5A);
        test_idle();
        test_single_read();
        test_write_read();
        test_starvation();
        test_illegal();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
